dpram_port_ctrl: RTL and testbench

- Controller in front of one dual-port RAM block (separate write and read ports, optional output register).
- Shares the RAM read port between two read clients using round-robin arbitration.
- Tags returning read data with a per-client valid pulse, timed to the RAM read latency.
- Owns the write port: passes through one write client and, optionally, runs a power-on clear sweep before normal operation.

---
 rtl/dpram_port_ctrl.sv | 179 +++++++++++++++++
 tb/tb_dpram_port_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_port_ctrl.sv
// Read-port arbiter and write-port owner for one simple dual-port RAM block.
// Define DPRAM_PORT_CTRL_CLEAR_EN to sweep CLEAR_VALUE through the RAM after reset.
module dpram_port_ctrl #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    ADDR_WIDTH  = 9,
    parameter int                    RD_LATENCY  = 2,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  c0_req,
    input  logic [ADDR_WIDTH-1:0] c0_addr,
    output logic                  c0_gnt,
    output logic                  c0_rvalid,
    input  logic                  c1_req,
    input  logic [ADDR_WIDTH-1:0] c1_addr,
    output logic                  c1_gnt,
    output logic                  c1_rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    input  logic                  w_req,
    input  logic [ADDR_WIDTH-1:0] w_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    output logic                  w_gnt,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    output logic                  ram_re,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_we
);

    localparam int NUM_CLIENTS = 2;

    generate
        if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
            $error("dpram_port_ctrl: RD_LATENCY must be 1 or 2");
        end
    endgenerate

    logic                  run;
    logic                  clear_active;
    logic [ADDR_WIDTH-1:0] clear_waddr;
    logic                  active;

`ifdef DPRAM_PORT_CTRL_CLEAR_EN
    localparam int DEPTH = 1 << ADDR_WIDTH;
    // One extra counter bit so the terminal compare can never be skipped by wrap-around.
    localparam logic [ADDR_WIDTH:0] LAST_CNT = (ADDR_WIDTH+1)'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                state_reg;
    state_t                state_next;
    logic [ADDR_WIDTH:0]   cnt_reg;
    logic [ADDR_WIDTH:0]   cnt_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_CLEAR;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        clear_active = 1'b0;
        case (state_reg)
            ST_CLEAR: begin
                clear_active = 1'b1;
                cnt_next     = cnt_reg + (ADDR_WIDTH+1)'(1);
                if (cnt_reg == LAST_CNT) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                state_next = ST_RUN;
            end
            default: begin
                state_next = ST_CLEAR;
            end
        endcase
    end

    assign run         = (state_reg == ST_RUN);
    assign clear_waddr = cnt_reg[ADDR_WIDTH-1:0];
`else
    assign run          = 1'b1;
    assign clear_active = 1'b0;
    assign clear_waddr  = '0;
`endif

    // Nothing is granted or written while reset is held, whatever the state register says.
    assign active    = rst_n & run;
    assign init_done = active;

    logic [NUM_CLIENTS-1:0] req;
    logic [ADDR_WIDTH-1:0]  req_addr [NUM_CLIENTS];
    logic [NUM_CLIENTS-1:0] gnt;
    logic [NUM_CLIENTS-1:0] rvalid;
    logic                   last_reg;
    logic [ADDR_WIDTH-1:0]  raddr_reg;

    assign req         = {c1_req, c0_req};
    assign req_addr[0] = c0_addr;
    assign req_addr[1] = c1_addr;

    // last_reg = 1 means client 1 was granted most recently, so client 0 wins a tie.
    assign gnt[0] = active & req[0] & (~req[1] | last_reg);
    assign gnt[1] = active & req[1] & (~req[0] | ~last_reg);

    always_comb begin
        ram_raddr = raddr_reg;
        if (gnt[0]) begin
            ram_raddr = req_addr[0];
        end else if (gnt[1]) begin
            ram_raddr = req_addr[1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_reg  <= 1'b1;
            raddr_reg <= '0;
        end else if (|gnt) begin
            last_reg  <= gnt[1];
            raddr_reg <= ram_raddr;
        end
    end

    assign ram_re = |gnt;
    assign c0_gnt = gnt[0];
    assign c1_gnt = gnt[1];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CLIENTS; gi++) begin : g_client
            logic [RD_LATENCY-1:0] pipe_reg;

            if (RD_LATENCY == 1) begin : g_lat1
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        pipe_reg <= '0;
                    end else begin
                        pipe_reg <= gnt[gi];
                    end
                end
            end else begin : g_latn
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        pipe_reg <= '0;
                    end else begin
                        pipe_reg <= {pipe_reg[RD_LATENCY-2:0], gnt[gi]};
                    end
                end
            end

            assign rvalid[gi] = rst_n & pipe_reg[RD_LATENCY-1];
        end
    endgenerate

    assign c0_rvalid = rvalid[0];
    assign c1_rvalid = rvalid[1];
    assign rdata     = ram_rdata;

    // The clear sweep owns the write port; afterwards the write client passes straight through.
    assign w_gnt     = active & w_req;
    assign ram_we    = rst_n & (clear_active | (run & w_req));
    assign ram_waddr = clear_active ? clear_waddr : w_addr;
    assign ram_wdata = clear_active ? CLEAR_VALUE : w_data;

endmodule

// File: tb/tb_dpram_port_ctrl.sv
// Directed bench: two controllers (read latency 2 and 1) each driving a behavioural RAM model.
// Honours DPRAM_PORT_CTRL_CLEAR_EN the same way the design does.
module tb_dpram_port_ctrl;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam logic [DW-1:0] CLR = 8'hA5;

    logic          clk;
    logic          rst_n;
    logic          c0_req, c1_req, w_req;
    logic [AW-1:0] c0_addr, c1_addr, w_addr;
    logic [DW-1:0] w_data;

    logic          l2_c0_gnt, l2_c0_rvalid, l2_c1_gnt, l2_c1_rvalid, l2_w_gnt, l2_init_done;
    logic          l2_ram_re, l2_ram_we;
    logic [DW-1:0] l2_rdata, l2_ram_rdata, l2_ram_wdata;
    logic [AW-1:0] l2_ram_raddr, l2_ram_waddr;

    logic          l1_c0_gnt, l1_c0_rvalid, l1_c1_gnt, l1_c1_rvalid, l1_w_gnt, l1_init_done;
    logic          l1_ram_re, l1_ram_we;
    logic [DW-1:0] l1_rdata, l1_ram_rdata, l1_ram_wdata;
    logic [AW-1:0] l1_ram_raddr, l1_ram_waddr;

    int checks = 0;
    int errors = 0;

    dpram_port_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(2), .CLEAR_VALUE(CLR)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .c0_req(c0_req), .c0_addr(c0_addr), .c0_gnt(l2_c0_gnt), .c0_rvalid(l2_c0_rvalid),
        .c1_req(c1_req), .c1_addr(c1_addr), .c1_gnt(l2_c1_gnt), .c1_rvalid(l2_c1_rvalid),
        .rdata(l2_rdata), .w_req(w_req), .w_addr(w_addr), .w_data(w_data), .w_gnt(l2_w_gnt),
        .init_done(l2_init_done), .ram_raddr(l2_ram_raddr), .ram_re(l2_ram_re),
        .ram_rdata(l2_ram_rdata), .ram_waddr(l2_ram_waddr), .ram_wdata(l2_ram_wdata),
        .ram_we(l2_ram_we)
    );

    dpram_port_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(1), .CLEAR_VALUE(CLR)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .c0_req(c0_req), .c0_addr(c0_addr), .c0_gnt(l1_c0_gnt), .c0_rvalid(l1_c0_rvalid),
        .c1_req(c1_req), .c1_addr(c1_addr), .c1_gnt(l1_c1_gnt), .c1_rvalid(l1_c1_rvalid),
        .rdata(l1_rdata), .w_req(w_req), .w_addr(w_addr), .w_data(w_data), .w_gnt(l1_w_gnt),
        .init_done(l1_init_done), .ram_raddr(l1_ram_raddr), .ram_re(l1_ram_re),
        .ram_rdata(l1_ram_rdata), .ram_waddr(l1_ram_waddr), .ram_wdata(l1_ram_wdata),
        .ram_we(l1_ram_we)
    );

    // RAM models: read-before-write, the latency-2 one with an output register.
    logic [DW-1:0] mem2 [16];
    logic [DW-1:0] mem1 [16];
    logic [DW-1:0] s1_q;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mem2[i] <= '0;
        end else if (l2_ram_we) begin
            mem2[l2_ram_waddr] <= l2_ram_wdata;
        end
        if (l2_ram_re) s1_q <= mem2[l2_ram_raddr];
        l2_ram_rdata <= s1_q;
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mem1[i] <= '0;
        end else if (l1_ram_we) begin
            mem1[l1_ram_waddr] <= l1_ram_wdata;
        end
        if (l1_ram_re) l1_ram_rdata <= mem1[l1_ram_raddr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Index 0 = latency-2 controller, index 1 = latency-1 controller.
    logic [1:0]    o_g0, o_g1, o_v0, o_v1, o_re, o_we, o_wg, o_init;
    logic [AW-1:0] o_ra [2];
    logic [AW-1:0] o_wa [2];
    logic [DW-1:0] o_wd [2];
    logic [DW-1:0] o_rd [2];
    assign o_g0   = {l1_c0_gnt, l2_c0_gnt};
    assign o_g1   = {l1_c1_gnt, l2_c1_gnt};
    assign o_v0   = {l1_c0_rvalid, l2_c0_rvalid};
    assign o_v1   = {l1_c1_rvalid, l2_c1_rvalid};
    assign o_re   = {l1_ram_re, l2_ram_re};
    assign o_we   = {l1_ram_we, l2_ram_we};
    assign o_wg   = {l1_w_gnt, l2_w_gnt};
    assign o_init = {l1_init_done, l2_init_done};
    assign o_ra[0] = l2_ram_raddr;
    assign o_ra[1] = l1_ram_raddr;
    assign o_wa[0] = l2_ram_waddr;
    assign o_wa[1] = l1_ram_waddr;
    assign o_wd[0] = l2_ram_wdata;
    assign o_wd[1] = l1_ram_wdata;
    assign o_rd[0] = l2_rdata;
    assign o_rd[1] = l1_rdata;

    typedef struct {
        logic c0r; logic [AW-1:0] c0a;
        logic c1r; logic [AW-1:0] c1a;
        logic wr;  logic [AW-1:0] wa; logic [DW-1:0] wd;
        logic g0;  logic g1; logic re; logic [AW-1:0] ra; logic we;
        logic v0;  logic v1; logic vk; logic [DW-1:0] vd;   // latency-2 expectations
        logic u0;  logic u1; logic uk; logic [DW-1:0] ud;   // latency-1 expectations
    } vec_t;

    vec_t vecs [22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic string dn(input int d);
        return (d == 0) ? "L2" : "L1";
    endfunction

    initial begin
        vecs[0]  = '{0,0, 1,2, 1,5,8'h3C, 0,1,1,2,1, 0,0,0,8'h00, 0,0,0,8'h00};
        vecs[1]  = '{1,5, 0,0, 0,0,8'h00, 1,0,1,5,0, 0,0,0,8'h00, 0,1,0,8'h00};
        vecs[2]  = '{0,0, 0,0, 0,0,8'h00, 0,0,0,5,0, 0,1,0,8'h00, 1,0,1,8'h3C};
        vecs[3]  = '{0,0, 0,0, 0,0,8'h00, 0,0,0,5,0, 1,0,1,8'h3C, 0,0,0,8'h00};
        vecs[4]  = '{0,0, 0,0, 1,9,8'h11, 0,0,0,5,1, 0,0,0,8'h00, 0,0,0,8'h00};
        vecs[5]  = '{1,9, 1,5, 0,0,8'h00, 0,1,1,5,0, 0,0,0,8'h00, 0,0,0,8'h00};
        vecs[6]  = '{1,9, 1,5, 0,0,8'h00, 1,0,1,9,0, 0,0,0,8'h00, 0,1,1,8'h3C};
        vecs[7]  = '{1,9, 1,5, 0,0,8'h00, 0,1,1,5,0, 0,1,1,8'h3C, 1,0,1,8'h11};
        vecs[8]  = '{1,9, 1,5, 0,0,8'h00, 1,0,1,9,0, 1,0,1,8'h11, 0,1,1,8'h3C};
        vecs[9]  = '{1,9, 1,5, 0,0,8'h00, 0,1,1,5,0, 0,1,1,8'h3C, 1,0,1,8'h11};
        vecs[10] = '{1,9, 1,5, 0,0,8'h00, 1,0,1,9,0, 1,0,1,8'h11, 0,1,1,8'h3C};
        vecs[11] = '{0,0, 0,0, 0,0,8'h00, 0,0,0,9,0, 0,1,1,8'h3C, 1,0,1,8'h11};
        vecs[12] = '{0,0, 0,0, 0,0,8'h00, 0,0,0,9,0, 1,0,1,8'h11, 0,0,0,8'h00};
        vecs[13] = '{0,0, 1,9, 1,9,8'h22, 0,1,1,9,1, 0,0,0,8'h00, 0,0,0,8'h00};
        vecs[14] = '{0,0, 1,9, 0,0,8'h00, 0,1,1,9,0, 0,0,0,8'h00, 0,1,1,8'h11};
        vecs[15] = '{0,0, 0,0, 0,0,8'h00, 0,0,0,9,0, 0,1,1,8'h11, 0,1,1,8'h22};
        vecs[16] = '{0,0, 0,0, 0,0,8'h00, 0,0,0,9,0, 0,1,1,8'h22, 0,0,0,8'h00};
        vecs[17] = '{1,5, 0,0, 0,0,8'h00, 1,0,1,5,0, 0,0,0,8'h00, 0,0,0,8'h00};
        vecs[18] = '{1,5, 0,0, 0,0,8'h00, 1,0,1,5,0, 0,0,0,8'h00, 1,0,1,8'h3C};
        vecs[19] = '{1,5, 0,0, 0,0,8'h00, 1,0,1,5,0, 1,0,1,8'h3C, 1,0,1,8'h3C};
        vecs[20] = '{0,0, 0,0, 0,0,8'h00, 0,0,0,5,0, 1,0,1,8'h3C, 1,0,1,8'h3C};
        vecs[21] = '{0,0, 0,0, 0,0,8'h00, 0,0,0,5,0, 1,0,1,8'h3C, 0,0,0,8'h00};

        // Reset with every request asserted: nothing may be granted or written.
        rst_n = 1'b0;
        c0_req = 1'b1; c0_addr = 4'd1;
        c1_req = 1'b1; c1_addr = 4'd2;
        w_req = 1'b1;  w_addr = 4'd3; w_data = 8'hEE;
        repeat (3) tick();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk({"reset c0_gnt ", dn(d)}, o_g0[d], 0);
            chk({"reset c1_gnt ", dn(d)}, o_g1[d], 0);
            chk({"reset ram_re ", dn(d)}, o_re[d], 0);
            chk({"reset ram_we ", dn(d)}, o_we[d], 0);
            chk({"reset w_gnt ", dn(d)}, o_wg[d], 0);
            chk({"reset rvalid ", dn(d)}, {o_v1[d], o_v0[d]}, 0);
            chk({"reset init_done ", dn(d)}, o_init[d], 0);
        end

        tick();
        w_req = 1'b0;
`ifdef DPRAM_PORT_CTRL_CLEAR_EN
        c0_req = 1'b1; c0_addr = 4'd7;
        c1_req = 1'b0;
        rst_n  = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("sweep%0d ram_we %s", k, dn(d)), o_we[d], 1);
                chk($sformatf("sweep%0d ram_waddr %s", k, dn(d)), o_wa[d], k);
                chk($sformatf("sweep%0d ram_wdata %s", k, dn(d)), o_wd[d], CLR);
                chk($sformatf("sweep%0d c0_gnt %s", k, dn(d)), o_g0[d], 0);
                chk($sformatf("sweep%0d init_done %s", k, dn(d)), o_init[d], 0);
            end
            tick();
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk({"post-sweep init_done ", dn(d)}, o_init[d], 1);
            chk({"post-sweep c0_gnt ", dn(d)}, o_g0[d], 1);
            chk({"post-sweep ram_we ", dn(d)}, o_we[d], 0);
        end
        tick();
        c0_req = 1'b0;
        @(negedge clk);
        chk("first read +1 c0_rvalid L1", l1_c0_rvalid, 1);
        chk("first read +1 rdata L1", l1_rdata, CLR);
        chk("first read +1 c0_rvalid L2", l2_c0_rvalid, 0);
        tick();
        @(negedge clk);
        chk("first read +2 c0_rvalid L2", l2_c0_rvalid, 1);
        chk("first read +2 rdata L2", l2_rdata, CLR);
        chk("first read +2 c0_rvalid L1", l1_c0_rvalid, 0);
        chk("first read +2 c1_rvalid L2", l2_c1_rvalid, 0);
`else
        c0_req = 1'b0;
        c1_req = 1'b1; c1_addr = 4'd0;
        rst_n  = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk({"first cycle init_done ", dn(d)}, o_init[d], 1);
            chk({"first cycle c1_gnt ", dn(d)}, o_g1[d], 1);
            chk({"first cycle ram_raddr ", dn(d)}, o_ra[d], 0);
        end
        tick();
        c1_req = 1'b0;
        @(negedge clk);
        chk("first read +1 c1_rvalid L1", l1_c1_rvalid, 1);
        chk("first read +1 rdata L1", l1_rdata, 0);
        chk("first read +1 c1_rvalid L2", l2_c1_rvalid, 0);
        tick();
        @(negedge clk);
        chk("first read +2 c1_rvalid L2", l2_c1_rvalid, 1);
        chk("first read +2 rdata L2", l2_rdata, 0);
        chk("first read +2 c1_rvalid L1", l1_c1_rvalid, 0);
        chk("first read +2 c0_rvalid L2", l2_c0_rvalid, 0);
`endif

        // Table: latency, round-robin, read-during-write, full throughput.
        for (int i = 0; i < 22; i++) begin
            tick();
            c0_req = vecs[i].c0r; c0_addr = vecs[i].c0a;
            c1_req = vecs[i].c1r; c1_addr = vecs[i].c1a;
            w_req  = vecs[i].wr;  w_addr  = vecs[i].wa; w_data = vecs[i].wd;
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                string p;
                logic ev0, ev1, ek;
                logic [DW-1:0] ed;
                p   = $sformatf("row%0d %s", i, dn(d));
                ev0 = (d == 0) ? vecs[i].v0 : vecs[i].u0;
                ev1 = (d == 0) ? vecs[i].v1 : vecs[i].u1;
                ek  = (d == 0) ? vecs[i].vk : vecs[i].uk;
                ed  = (d == 0) ? vecs[i].vd : vecs[i].ud;
                chk({p, " c0_gnt"}, o_g0[d], vecs[i].g0);
                chk({p, " c1_gnt"}, o_g1[d], vecs[i].g1);
                chk({p, " ram_re"}, o_re[d], vecs[i].re);
                chk({p, " ram_raddr"}, o_ra[d], vecs[i].ra);
                chk({p, " ram_we"}, o_we[d], vecs[i].we);
                chk({p, " w_gnt"}, o_wg[d], vecs[i].we);
                chk({p, " init_done"}, o_init[d], 1);
                chk({p, " c0_rvalid"}, o_v0[d], ev0);
                chk({p, " c1_rvalid"}, o_v1[d], ev1);
                if (vecs[i].wr) begin
                    chk({p, " ram_waddr"}, o_wa[d], vecs[i].wa);
                    chk({p, " ram_wdata"}, o_wd[d], vecs[i].wd);
                end
                if (ek) chk({p, " rdata"}, o_rd[d], ed);
            end
        end

        // Reset one cycle after a grant: the in-flight read must vanish.
        tick();
        c0_req = 1'b1; c0_addr = 4'd5;
        c1_req = 1'b0; w_req = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) chk({"pre-reset c0_gnt ", dn(d)}, o_g0[d], 1);
        tick();
        rst_n = 1'b0;
        c0_req = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk({"in-reset rvalid ", dn(d)}, {o_v1[d], o_v0[d]}, 0);
            chk({"in-reset c0_gnt ", dn(d)}, o_g0[d], 0);
        end
        tick();
        rst_n = 1'b1;
        c0_req = 1'b1; c0_addr = 4'd3;
        c1_req = 1'b1; c1_addr = 4'd4;
        @(negedge clk);
        for (int d = 0; d < 2; d++) chk({"post-reset rvalid ", dn(d)}, {o_v1[d], o_v0[d]}, 0);
`ifdef DPRAM_PORT_CTRL_CLEAR_EN
        for (int d = 0; d < 2; d++) begin
            chk({"restart ram_waddr ", dn(d)}, o_wa[d], 0);
            chk({"restart ram_we ", dn(d)}, o_we[d], 1);
            chk({"restart init_done ", dn(d)}, o_init[d], 0);
            chk({"restart c0_gnt ", dn(d)}, o_g0[d], 0);
        end
        for (int k = 1; k < 16; k++) begin
            tick();
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("resweep%0d ram_waddr %s", k, dn(d)), o_wa[d], k);
                chk($sformatf("resweep%0d gnt %s", k, dn(d)), {o_g1[d], o_g0[d]}, 0);
            end
        end
        tick();
        @(negedge clk);
`endif
        // First contested cycle after reset: client 0 wins, then client 1.
        for (int d = 0; d < 2; d++) begin
            chk({"rr first c0_gnt ", dn(d)}, o_g0[d], 1);
            chk({"rr first c1_gnt ", dn(d)}, o_g1[d], 0);
            chk({"rr first ram_raddr ", dn(d)}, o_ra[d], 3);
            chk({"rr first init_done ", dn(d)}, o_init[d], 1);
        end
        tick();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk({"rr second c1_gnt ", dn(d)}, o_g1[d], 1);
            chk({"rr second c0_gnt ", dn(d)}, o_g0[d], 0);
            chk({"rr second ram_raddr ", dn(d)}, o_ra[d], 4);
        end
        chk("rr second c0_rvalid L1", l1_c0_rvalid, 1);
        chk("rr second rvalid L2", {l2_c1_rvalid, l2_c0_rvalid}, 0);
        tick();
        c0_req = 1'b0; c1_req = 1'b0;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
